// File: rtl/branch_predictor_gshare.sv
// Gshare / bimodal branch direction predictor.
// Table of saturating counters, swept to weakly-not-taken after reset.
package bp_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_t;
endpackage

module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 6,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = 1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output branch_outcome_t       o_req_prediction,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  branch_outcome_t       i_fb_prediction,
    input  branch_outcome_t       i_fb_outcome,
    output logic                  o_ready,
    output logic [31:0]           o_mispredict_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [CTR_BITS-1:0] C_WEAK =
        CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] C_MAX  = '1;
    localparam logic [CTR_BITS-1:0] C_MIN  = '0;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [INDEX_BITS-1:0]   r_ptr;
    logic [INDEX_BITS-1:0]   w_ptr_nxt;
    logic [HIST_BITS-1:0]    r_hist;
    logic [HIST_BITS-1:0]    w_hist_nxt;
    logic [31:0]             r_mis_cnt;
    logic [31:0]             w_mis_cnt_nxt;

    logic [CTR_BITS-1:0]     r_tbl [ENTRIES];

    logic                    w_we;
    logic [INDEX_BITS-1:0]   w_waddr;
    logic [CTR_BITS-1:0]     w_wdata;

    logic [INDEX_BITS-1:0]   w_hist_ext;
    logic [INDEX_BITS-1:0]   w_req_base;
    logic [INDEX_BITS-1:0]   w_fb_base;
    logic [INDEX_BITS-1:0]   w_req_idx;
    logic [INDEX_BITS-1:0]   w_fb_idx;
    logic [CTR_BITS-1:0]     w_fb_ctr;
    logic [CTR_BITS-1:0]     w_fb_ctr_nxt;
    logic                    w_fb_taken;
    logic                    w_fb_miss;
    branch_outcome_t         w_pred;
    logic                    w_ready;
    logic                    w_unused;

    // Request valid and PC bits outside the index never affect the result.
    assign w_unused = ^{i_req_valid, i_req_pc, i_fb_pc};

    assign w_hist_ext = INDEX_BITS'(r_hist);
    assign w_req_base = i_req_pc[INDEX_BITS+1:2];
    assign w_fb_base  = i_fb_pc[INDEX_BITS+1:2];

    // History only folds into the index in gshare mode.
    assign w_req_idx = (MODE == 1) ? (w_req_base ^ w_hist_ext)
                                   : w_req_base;
    assign w_fb_idx  = (MODE == 1) ? (w_fb_base ^ w_hist_ext)
                                   : w_fb_base;

    assign w_fb_taken = (i_fb_outcome == TAKEN);
    assign w_fb_miss  = (i_fb_prediction != i_fb_outcome);
    assign w_fb_ctr   = r_tbl[w_fb_idx];

    // Saturating up/down step of the counter hit by feedback.
    always_comb begin
        w_fb_ctr_nxt = w_fb_ctr;
        if (w_fb_taken) begin
            if (w_fb_ctr != C_MAX) begin
                w_fb_ctr_nxt = w_fb_ctr + 1'b1;
            end
        end else begin
            if (w_fb_ctr != C_MIN) begin
                w_fb_ctr_nxt = w_fb_ctr - 1'b1;
            end
        end
    end

    // State, sweep pointer, history and miss counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_ptr     <= '0;
            r_hist    <= '0;
            r_mis_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hist    <= w_hist_nxt;
            r_mis_cnt <= w_mis_cnt_nxt;
        end
    end

    // Next state, single table write port and outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hist_nxt    = r_hist;
        w_mis_cnt_nxt = r_mis_cnt;
        w_we          = 1'b0;
        w_waddr       = r_ptr;
        w_wdata       = C_WEAK;
        w_ready       = 1'b0;
        w_pred        = NOT_TAKEN;
        unique case (r_state)
            S_INIT: begin
                w_we      = 1'b1;
                w_waddr   = r_ptr;
                w_wdata   = C_WEAK;
                w_ptr_nxt = r_ptr + 1'b1;
                if (&r_ptr) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_ready = 1'b1;
                w_pred  = r_tbl[w_req_idx][CTR_BITS-1]
                          ? TAKEN : NOT_TAKEN;
                if (i_fb_valid) begin
                    w_we       = 1'b1;
                    w_waddr    = w_fb_idx;
                    w_wdata    = w_fb_ctr_nxt;
                    w_hist_nxt = HIST_BITS'({r_hist, w_fb_taken});
                    if (w_fb_miss && (r_mis_cnt != 32'hFFFF_FFFF)) begin
                        w_mis_cnt_nxt = r_mis_cnt + 32'd1;
                    end
                end
            end
        endcase
    end

    // Counter table: one write port, no reset so it maps to LUT RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_tbl[w_waddr] <= w_wdata;
        end
    end

    assign o_ready          = w_ready;
    assign o_req_prediction = w_pred;
    assign o_mispredict_cnt = r_mis_cnt;

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter INDEX_BITS, default 6, log2 of pattern-table entry count (range 2..10).
REQ-002 Parameter HIST_BITS, default 6, global history register width (1..INDEX_BITS).
REQ-003 Parameter CTR_BITS, default 2, saturating counter width per entry (1..4).
REQ-004 Parameter MODE, default 1; 0 = bimodal (PC-only index), 1 = gshare (PC XOR history index).
REQ-005 Port clk, input, 1, the single block clock.
REQ-006 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 Port i_req_valid, input, 1, decode requests a prediction this cycle.
REQ-008 Port i_req_pc, input, ADDR_WIDTH, PC of branch in decode.
REQ-009 Port o_req_prediction, output, BranchOutcome, predicted direction.
REQ-010 Port i_fb_valid, input, 1, resolved-branch feedback from execute.
REQ-011 Port i_fb_pc, input, ADDR_WIDTH, PC of resolved branch.
REQ-012 Port i_fb_prediction, input, BranchOutcome, prediction originally issued.
REQ-013 Port i_fb_outcome, input, BranchOutcome, actual direction.
REQ-014 Port o_ready, output, 1, table initialised, predictor active.
REQ-015 Port o_mispredict_cnt, output, 32, saturating count of mispredicted feedbacks.

Function
REQ-016 The block SHALL have two states, INIT and RUN, with INIT entered on reset.
REQ-017 In INIT, the block SHALL write one entry per cycle, at pointer 0..2^INDEX_BITS-1, to weakly-not-taken (2^(CTR_BITS-1)-1), then enter RUN the cycle after the last write.
REQ-018 o_ready SHALL be 1 exactly when the state is RUN.
REQ-019 In INIT, o_req_prediction SHALL be NOT_TAKEN, feedback SHALL be ignored, and history and count SHALL hold.
REQ-020 Base index SHALL be pc[INDEX_BITS+1:2]; in MODE 1, the base index SHALL be XORed with the history zero-extended to INDEX_BITS.
REQ-021 In RUN, o_req_prediction SHALL be combinational from the current table and history: TAKEN if the indexed counter MSB is 1, else NOT_TAKEN; i_req_valid SHALL not gate the output.
REQ-022 On i_fb_valid in RUN, the block SHALL compute the feedback index from i_fb_pc and the pre-update history.
REQ-023 On the next clk edge after such feedback, the counter SHALL increment on TAKEN and decrement on NOT_TAKEN, saturating at 2^CTR_BITS-1 and 0.
REQ-024 On the same edge, history SHALL shift left by one with i_fb_outcome (TAKEN=1) entering bit 0 and the MSB discarded; in MODE 0, history SHALL still shift but SHALL be unused.
REQ-025 When a request and a feedback hit the same entry in one cycle, the request SHALL see the pre-update value (no bypass).
REQ-026 On RUN feedback where i_fb_prediction != i_fb_outcome, o_mispredict_cnt SHALL increment by 1, holding at 2^32-1.
REQ-027 Table storage SHALL have one write port and be synthesisable as registers or distributed RAM.

Reset
REQ-028 While rst_n=0, the block SHALL clear state to INIT, pointer, history and o_mispredict_cnt to 0, and drive o_ready=0 and o_req_prediction=NOT_TAKEN, all asynchronously.
REQ-029 Reset asserted mid-RUN or mid-INIT SHALL restart the full initialisation sweep after release.
REQ-030 Table contents SHALL not be reset asynchronously; only the INIT sweep initialises them.

Verification (INDEX_BITS=4, HIST_BITS=4, CTR_BITS=2 unless noted)
REQ-031 Release reset -> o_ready=0 for 16 cycles, 1 from cycle 17; o_req_prediction NOT_TAKEN throughout.
REQ-032 MODE 0, RUN, one TAKEN feedback at pc 0x10 -> next cycle pc 0x10 predicts TAKEN and pc 0x14 predicts NOT_TAKEN.
REQ-033 MODE 0, five TAKEN then one NOT_TAKEN at pc 0x10 -> counter 3 then 2, prediction stays TAKEN; three further NOT_TAKEN -> counter 0, NOT_TAKEN, with no underflow.
REQ-034 MODE 1, history 0, TAKEN feedback at pc 0x10 -> entry 4 set to 2 and history becomes 0001; request pc 0x10 indexes entry 5 and predicts NOT_TAKEN.
REQ-035 Three feedbacks with prediction NOT_TAKEN and outcome TAKEN -> o_mispredict_cnt=3; a mismatching feedback during INIT is not counted; same-cycle request/feedback to one entry returns the old value.
REQ-036 Assert rst_n low for 1 cycle mid-RUN with count 5 -> o_ready, o_mispredict_cnt and history 0 immediately; 16-cycle sweep repeats; all entries predict NOT_TAKEN afterward.
